div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
// Iterative multi-cycle divider sequencer that sits beside the ex stage.
// Handles div/divu: captures operands on start_i, runs one restoring-division
// step per clock for WIDTH cycles, and returns {remainder, quotient} for HI/LO.
// Raises stallreq_o toward the pipeline controller while a division is in
// flight, and accepts annul_i to abort on flush or exception.
// PARAMETERS
// WIDTH   32   operand width; quotient and remainder are WIDTH bits each
// PORTS
// clk          in   1         clock, rising edge
// rst          in   1         reset, asynchronous, active-high (RstEnable)
// signed_div_i in   1         1 = signed (div), 0 = unsigned (divu)
// opdata1_i    in   WIDTH     dividend
// opdata2_i    in   WIDTH     divisor
// start_i      in   1         division request; held high by ex until ready_o
// annul_i      in   1         abort the current or pending division
// result_o     out  2*WIDTH   {remainder[2W-1:W], quotient[W-1:0]}
// ready_o      out  1         result_o valid
// stallreq_o   out  1         combinational stall request to the pipeline controller
// BEHAVIOUR
// - Reset (async, any state, including mid-division): state=IDLE, cnt=0,
//   result_o=0, ready_o=0. Internal dividend/divisor registers are cleared.
// - FSM states, 2-bit: IDLE, BYZERO, RUN, DONE.
// - IDLE: if start_i=1 and annul_i=0: when opdata2_i==0, go to BYZERO.
//   Otherwise capture |op1| and |op2| and go to RUN with cnt=0. An operand
//   is negated (two's complement) only when signed_div_i=1 and its MSB=1.
//   The signs and signed_div_i are latched at the same time.
//   If start_i and annul_i are both 1, annul wins and the FSM stays in IDLE.
// - RUN: each edge does one restoring step.
//   - Shift {rem, dividend} left by 1.
//   - trial = rem - divisor, evaluated as a (WIDTH+1)-bit subtraction.
//   - If trial is non-negative, rem=trial and the quotient LSB is 1; otherwise
//     rem is unchanged and the quotient LSB is 0.
//   - cnt increments; on the edge where cnt==WIDTH-1, go to DONE.
//   - On that same edge, load result_o with the sign-corrected values:
//     - quotient is negated if signed and sign(op1) != sign(op2);
//     - remainder is negated if signed and op1 was negative.
//   - ready_o=1 on that same edge.
//   - Operand changes during RUN are ignored; the captured copies are used.
//   - start_i falling during RUN is ignored; only annul_i aborts.
// - annul_i=1 in RUN or BYZERO: on the next edge go to IDLE with cnt=0,
//   result_o=0, ready_o=0. Nothing is ever reported for the aborted division.
// - BYZERO: on the next edge go to DONE with result_o=0 and ready_o=1.
// - DONE: hold result_o and ready_o while start_i=1.
//   When start_i=0, on the next edge go to IDLE with ready_o=0 and result_o=0.
//   annul_i in DONE behaves the same as start_i=0.
// - Latency, counting the edge that samples start_i as edge 1:
//   - normal division: ready_o=1 after edge WIDTH+1 (edge 33 at WIDTH=32);
//   - divide-by-zero: ready_o=1 after edge 2.
// - stallreq_o = start_i & ~annul_i & (state != DONE). It drops in the same
//   cycle ready_o rises.
// - Corner case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000
//   (wraps) and remainder 0. There is no overflow flag.
// TESTING
// 1 divu 100/7, start held high -> stallreq_o=1 for 32 cycles; ready_o=1
//   after edge 33; result_o={32'd2,32'd14}.
// 2 div 0xFFFFFFF9 / 2 (-7/2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//   div 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 0x00000001.
// 3 div 5/0 -> ready_o=1 after edge 2; result_o=0. Also cover signed
//   0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
// 4 annul_i pulsed at RUN cycle 10 -> IDLE on the next edge; ready_o never
//   rises. A new divu 9/3 then completes normally with {0, 3}.
// 5 rst asserted asynchronously mid-RUN, between edges -> result_o=0,
//   ready_o=0, stallreq_o follows start_i. After release, a new start runs
//   the full WIDTH+1 latency.
// 6 In DONE, hold start_i for 5 cycles -> result_o stable and ready_o=1.
//   Drop start_i -> ready_o=0 and result_o=0 after the next edge.
//   Asserting start_i and annul_i together in IDLE -> the FSM stays in IDLE.

Source files
------------

// File: rtl/div_seq.sv
// Iterative restoring divider (div/divu) beside the ex stage; {remainder, quotient} for HI/LO.
// Latency: ready_o after WIDTH+1 edges from the start_i sample, 2 edges for divide-by-zero.
// Backpressure: stallreq_o holds the pipeline until ready_o; DONE holds the result while start_i stays high.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr;      // magnitude of the divisor
  logic             q_neg;    // quotient needs negation at the end
  logic             r_neg;    // remainder needs negation at the end

  logic             go;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   rem_sh, trial;
  logic             trial_neg;
  logic [WIDTH-1:0] rem_step, q_step, q_fin, r_fin;

  // Operand magnitudes: negate only signed operands with their MSB set.
  // The most negative value negates to itself, which is the correct unsigned magnitude.
  assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
  assign go   = start_i & ~annul_i;

  // One restoring step: shift {rem, dvd} left, try subtracting the divisor with one guard bit.
  assign rem_sh    = {rem, dvd[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, dsr};
  assign trial_neg = trial[WIDTH];
  assign rem_step  = trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_step    = {dvd[WIDTH-2:0], ~trial_neg};
  assign q_fin     = q_neg ? (~q_step + 1'b1) : q_step;
  assign r_fin     = r_neg ? (~rem_step + 1'b1) : rem_step;

  assign stallreq_o = start_i & ~annul_i & (state != DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; annul always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = (opdata2_i == '0) ? BYZERO : RUN;
      BYZERO:  state_nxt = annul_i ? IDLE : DONE;
      RUN: begin
        if (annul_i)              state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE:    if (!start_i || annul_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and the result/ready registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go && opdata2_i != '0) begin
            dvd   <= abs1;
            dsr   <= abs2;
            rem   <= '0;
            cnt   <= '0;
            q_neg <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg <= signed_div_i & opdata1_i[WIDTH-1];
          end
        end
        RUN: begin
          if (annul_i) begin
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            rem <= rem_step;
            dvd <= q_step;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              result_o <= {r_fin, q_fin};
              ready_o  <= 1'b1;
            end
          end
        end
        BYZERO: begin
          result_o <= '0;
          ready_o  <= ~annul_i;
        end
        DONE: begin
          if (!start_i || annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq at WIDTH=32: latency, signed/unsigned results, annul, reset, DONE hold.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready, stallreq;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch a division (called on a falling edge) and wait, bounded, for ready.
  // edges: edges up to and including the one that raised ready (100 = timeout).
  // stalls: cycles with stallreq high between edge 1 and ready.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output logic [63:0] res, output int stalls,
                         output logic stall_first, output logic stall_end);
    signed_div = sgn; op1 = a; op2 = b; annul = 1'b0; start = 1'b1;
    #1 stall_first = stallreq;
    edges = 0; stalls = 0;
    while (edges < 100) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (ready) break;
      if (stallreq) stalls++;
    end
    res = result;
    stall_end = stallreq;
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    #3;
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stallreq); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu();
    int e, s; logic [63:0] r; logic sf, se;
    run_div(1'b0, 32'd100, 32'd7, e, r, s, sf, se);
    n_checks++; if (e !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", e); end
    n_checks++; if (r !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_result: got %h expected %h", r, {32'd2, 32'd14}); end
    n_checks++; if (sf !== 1'b1) begin n_fail++; $display("FAIL divu_stall_first: got %b expected 1", sf); end
    n_checks++; if (s !== 32) begin n_fail++; $display("FAIL divu_stall_cycles: got %0d expected 32", s); end
    n_checks++; if (se !== 1'b0) begin n_fail++; $display("FAIL divu_stall_at_ready: got %b expected 0", se); end
    drop_start();
  endtask

  task automatic test_signed();
    int e, s; logic [63:0] r; logic sf, se;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, e, r, s, sf, se);
    n_checks++; if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL div_neg7_by_2: got %h expected ffffffff_fffffffd", r); end
    n_checks++; if (e !== 33) begin n_fail++; $display("FAIL div_neg7_latency: got %0d expected 33", e); end
    drop_start();
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, e, r, s, sf, se);
    n_checks++; if (r !== {32'h0000_0001, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL div_7_by_neg2: got %h expected 00000001_fffffffd", r); end
    drop_start();
    // Same bit pattern unsigned: 0xFFFFFFF9 / 2 = 0x7FFFFFFC rem 1.
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, e, r, s, sf, se);
    n_checks++; if (r !== {32'd1, 32'h7FFF_FFFC}) begin n_fail++; $display("FAIL divu_big_by_2: got %h expected 00000001_7ffffffc", r); end
    drop_start();
  endtask

  task automatic test_corners();
    int e, s; logic [63:0] r; logic sf, se;
    run_div(1'b1, 32'd5, 32'd0, e, r, s, sf, se);
    n_checks++; if (e !== 2) begin n_fail++; $display("FAIL byzero_latency: got %0d expected 2", e); end
    n_checks++; if (r !== 64'd0) begin n_fail++; $display("FAIL byzero_result: got %h expected 0", r); end
    drop_start();
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e, r, s, sf, se);
    n_checks++; if (r !== {32'd0, 32'h8000_0000}) begin n_fail++; $display("FAIL div_min_by_neg1: got %h expected 00000000_80000000", r); end
    drop_start();
  endtask

  task automatic test_annul();
    int e, s; logic [63:0] r; logic sf, se;
    logic seen_ready;
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; annul = 1'b0; start = 1'b1;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    annul = 1'b1;
    #1;
    n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL annul_stall: got %b expected 0", stallreq); end
    @(posedge clk); @(negedge clk);
    annul = 1'b0; start = 1'b0;
    seen_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (ready) seen_ready = 1'b1;
    end
    n_checks++; if (seen_ready !== 1'b0) begin n_fail++; $display("FAIL annul_no_ready: got %b expected 0", seen_ready); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL annul_result: got %h expected 0", result); end
    run_div(1'b0, 32'd9, 32'd3, e, r, s, sf, se);
    n_checks++; if (r !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL after_annul_result: got %h expected 00000000_00000003", r); end
    n_checks++; if (e !== 33) begin n_fail++; $display("FAIL after_annul_latency: got %0d expected 33", e); end
    drop_start();
  endtask

  task automatic test_async_reset();
    int e, s; logic [63:0] r; logic sf, se;
    // Reset while holding a result in DONE, between edges.
    run_div(1'b0, 32'd77, 32'd5, e, r, s, sf, se);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL rst_done_result: got %h expected 0", result); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_done_ready: got %b expected 0", ready); end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(negedge clk);
    // Reset mid-RUN, between edges.
    signed_div = 1'b0; op1 = 32'd12345; op2 = 32'd17; start = 1'b1;
    repeat (15) begin @(posedge clk); @(negedge clk); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ready !== 1'b0 || result !== 64'd0) begin n_fail++; $display("FAIL rst_run_outputs: got ready=%b result=%h expected 0/0", ready, result); end
    n_checks++; if (stallreq !== start) begin n_fail++; $display("FAIL rst_run_stall: got %b expected %b", stallreq, start); end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(negedge clk);
    run_div(1'b0, 32'd12345, 32'd17, e, r, s, sf, se);
    n_checks++; if (e !== 33) begin n_fail++; $display("FAIL rst_restart_latency: got %0d expected 33", e); end
    n_checks++; if (r !== {32'd3, 32'd726}) begin n_fail++; $display("FAIL rst_restart_result: got %h expected 00000003_000002d6", r); end
    drop_start();
  endtask

  task automatic test_done_hold();
    int e, s; logic [63:0] r; logic sf, se;
    logic stable;
    run_div(1'b0, 32'd50, 32'd6, e, r, s, sf, se);
    n_checks++; if (r !== {32'd2, 32'd8}) begin n_fail++; $display("FAIL hold_result: got %h expected 00000002_00000008", r); end
    // Operands wander while DONE holds; the result must not move.
    stable = 1'b1;
    repeat (5) begin
      op1 = $urandom; op2 = $urandom;
      @(posedge clk); @(negedge clk);
      if (ready !== 1'b1 || result !== {32'd2, 32'd8}) stable = 1'b0;
    end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got %b expected 1", stable); end
    start = 1'b0;
    #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL hold_before_edge: got %b expected 1", ready); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (ready !== 1'b0 || result !== 64'd0) begin n_fail++; $display("FAIL release_outputs: got ready=%b result=%h expected 0/0", ready, result); end
    // start and annul together in IDLE: nothing may begin.
    op1 = 32'd40; op2 = 32'd4; start = 1'b1; annul = 1'b1;
    #1;
    n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL idle_annul_stall: got %b expected 0", stallreq); end
    repeat (3) begin @(posedge clk); @(negedge clk); end
    run_div(1'b0, 32'd40, 32'd4, e, r, s, sf, se);
    n_checks++; if (e !== 33) begin n_fail++; $display("FAIL idle_annul_latency: got %0d expected 33", e); end
    n_checks++; if (r !== {32'd0, 32'd10}) begin n_fail++; $display("FAIL idle_annul_result: got %h expected 00000000_0000000a", r); end
    drop_start();
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_corners();
    test_annul();
    test_async_reset();
    test_done_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
